// File: rtl/exec_arith_unit.sv
// Execute-stage arithmetic core: ALU control decode, ALU, zero flag and
// branch-target adder, all captured into the EX/MEM boundary register.
module exec_arith_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] imm_ext,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_addr,
  output logic [2:0]       alu_ctrl
);

  // ALU operation encodings
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // EX/MEM boundary contents
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] br_addr;
    logic [2:0]       ctrl;
  } exmem_t;

  exmem_t           exmem_d, exmem_q;
  logic [2:0]       ctrl_d;
  logic [WIDTH-1:0] res_d;
  logic [5:0]       funct;

  assign funct = imm_ext[5:0];

  // Decode ALUop + funct into the 3-bit ALU operation; unknowns fall back to add
  always_comb begin
    ctrl_d = OP_ADD;
    unique case (alu_op)
      2'b00: ctrl_d = OP_ADD;
      2'b01: ctrl_d = OP_SUB;
      2'b11: ctrl_d = OP_ADD;
      2'b10: begin
        case (funct)
          6'b100000: ctrl_d = OP_ADD;
          6'b100010: ctrl_d = OP_SUB;
          6'b100100: ctrl_d = OP_AND;
          6'b100101: ctrl_d = OP_OR;
          6'b100110: ctrl_d = OP_XOR;
          6'b100111: ctrl_d = OP_NOR;
          6'b101010: ctrl_d = OP_SLT;
          default:   ctrl_d = OP_ADD;
        endcase
      end
      default: ctrl_d = OP_ADD;
    endcase
  end

  // ALU datapath; SLT uses a signed compare so it stays correct across overflow
  always_comb begin
    res_d = '0;
    case (ctrl_d)
      OP_AND:  res_d = src_a & src_b;
      OP_OR:   res_d = src_a | src_b;
      OP_ADD:  res_d = src_a + src_b;
      OP_XOR:  res_d = src_a ^ src_b;
      OP_NOR:  res_d = ~(src_a | src_b);
      OP_SUB:  res_d = src_a - src_b;
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: res_d = '0;
    endcase
  end

  // Assemble next boundary value; branch offset drops the top two imm bits
  always_comb begin
    exmem_d         = '0;
    exmem_d.result  = res_d;
    exmem_d.zero    = (res_d == '0);
    exmem_d.br_addr = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00};
    exmem_d.ctrl    = ctrl_d;
  end

  // EX/MEM register; reset value reports the add encoding as idle control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_q.result  <= '0;
      exmem_q.zero    <= 1'b0;
      exmem_q.br_addr <= '0;
      exmem_q.ctrl    <= OP_ADD;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign alu_result  = exmem_q.result;
  assign zero        = exmem_q.zero;
  assign branch_addr = exmem_q.br_addr;
  assign alu_ctrl    = exmem_q.ctrl;

endmodule

// File: tb/tb_exec_arith_unit.sv
// Bench for exec_arith_unit: directed cases plus randomized ops against a
// behavioural model of the MIPS execute stage.
module tb_exec_arith_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  alu_op;
  logic [31:0] src_a, src_b, pc_plus4, imm_ext;
  logic [31:0] alu_result, branch_addr;
  logic        zero;
  logic [2:0]  alu_ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  exec_arith_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .pc_plus4(pc_plus4), .imm_ext(imm_ext), .alu_result(alu_result),
    .zero(zero), .branch_addr(branch_addr), .alu_ctrl(alu_ctrl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: control code from the MIPS opcode table
  function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b01) return 3'b110;
    if (op != 2'b10) return 3'b010;
    case (fn)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h26: return 3'b011;
      6'h27: return 3'b100;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Reference: result using wide integer arithmetic, truncated to 32 bits
  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (c)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
      3'b110: return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'b011: return a ^ b;
      3'b100: return ~(a | b);
      3'b111: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_br(input logic [31:0] pc, input logic [31:0] imm);
    return 32'((longint'(pc) + longint'(imm) * 4) % 64'h1_0000_0000);
  endfunction

  // Present one operation, clock it, then compare against the model
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm);
    logic [2:0]  ec;
    logic [31:0] er;
    alu_op = op; src_a = a; src_b = b; pc_plus4 = pc; imm_ext = imm;
    ec = ref_ctrl(op, imm[5:0]);
    er = ref_alu(ec, a, b);
    @(posedge clk); #1;
    chk({tag, ".res"},  alu_result, er);
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, er == 32'd0});
    chk({tag, ".br"},   branch_addr, ref_br(pc, imm));
    chk({tag, ".ctrl"}, {29'd0, alu_ctrl}, {29'd0, ec});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".res"},  alu_result, 32'd0);
    chk({tag, ".zero"}, {31'd0, zero}, 32'd0);
    chk({tag, ".br"},   branch_addr, 32'd0);
    chk({tag, ".ctrl"}, {29'd0, alu_ctrl}, 32'd2);
  endtask

  logic [5:0] fn_tab [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00};

  initial begin
    rst_n = 1'b0;
    alu_op = 2'b10; src_a = $urandom; src_b = $urandom;
    pc_plus4 = $urandom; imm_ext = $urandom;
    // Held in reset across edges with random inputs
    repeat (3) @(posedge clk);
    #1 chk_reset("rst");
    #3 rst_n = 1'b1;

    run_op("add5_7", 2'b00, 32'd5, 32'd7, 32'd0, 32'd0);

    // R-type funct sweep with A=12, B=10
    foreach (fn_tab[i]) run_op($sformatf("rtype%0d", i), 2'b10, 32'hC, 32'hA, 32'h100, {26'd0, fn_tab[i]});
    run_op("op11", 2'b11, 32'd3, 32'd4, 32'd8, 32'h22);

    // Branch compare
    run_op("beq_eq", 2'b01, 32'h1234, 32'h1234, 32'd0, 32'd0);
    run_op("beq_ne", 2'b01, 32'h1234, 32'h1235, 32'd0, 32'd0);

    // Signed SLT and wrap
    run_op("slt_m1", 2'b10, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h2A);
    run_op("slt_ovf", 2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'h2A);
    run_op("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);

    // Branch target
    run_op("br_pos", 2'b00, 32'd0, 32'd0, 32'd40, 32'd3);
    run_op("br_neg", 2'b00, 32'd0, 32'd0, 32'd40, 32'hFFFF_FFFE);
    run_op("br_wrap", 2'b00, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd1);

    // Back-to-back ops, then asynchronous reset mid-stream
    for (int i = 0; i < 4; i++)
      run_op($sformatf("pipe%0d", i), 2'(i), $urandom, $urandom, $urandom, {$urandom_range(0, 65535), fn_tab[i]});
    alu_op = 2'b00; src_a = 32'd1; src_b = 32'd2;
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    // Edge while reset low must not capture
    @(posedge clk); #1 chk_reset("rst_edge");
    #3 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b, imm;
      a = $urandom; b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      imm = $urandom;
      imm[5:0] = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) imm[31:16] = {16{imm[15]}};
      run_op($sformatf("rnd%0d", i), 2'($urandom), a, b, $urandom, imm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
